// File: rtl/deal_sequencer_if.sv
// Purpose : Bundles the score feedback and control outputs exchanged between
//           the Baccarat deal sequencer and the card datapath.
// Signals :
//   pscore_out, dscore_out  datapath -> sequencer, scores 0..9 (10..15 read as 9)
//   pcard3_out              datapath -> sequencer, player third card rank
//   load_pcard1..3          sequencer -> datapath, player card load strobes
//   load_dcard1..3          sequencer -> datapath, dealer card load strobes
//   player_win_light        sequencer -> lamps, player won (both high = tie)
//   dealer_win_light        sequencer -> lamps, dealer won
//   hand_done               sequencer -> system, hand resolved
// Modports: master = sequencer side, slave = datapath side.
interface deal_sequencer_if;
  logic [3:0] pscore_out;
  logic [3:0] dscore_out;
  logic [3:0] pcard3_out;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       hand_done;

  modport master (
    input  pscore_out, dscore_out, pcard3_out,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, hand_done
  );

  modport slave (
    output pscore_out, dscore_out, pcard3_out,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, hand_done
  );
endinterface

// File: rtl/deal_sequencer.sv
// Purpose : Baccarat deal controller. Issues the card-load strobes in dealing
//           order, applies the player and banker third-card rules from the
//           datapath scores, then resolves the hand and drives the win lights.
// Ports   :
//   slow_clock  in  sole clock, rising edge
//   reset       in  synchronous, active-high
//   bus         deal_sequencer_if.master (scores in; strobes, lights, hand_done out)
// Config  : define DEAL_PACE_EN to hold each deal state for PACE_CYCLES cycles
//           (1..15) with the strobe in the final cycle; without it every deal
//           state lasts one cycle.
//
// state | meaning
// IDLE  | waiting after reset, no outputs
// P1    | load player card 1
// D1    | load dealer card 1
// P2    | load player card 2
// D2    | load dealer card 2
// EVAL  | natural / player third-card decision on 4-card scores
// P3    | load player card 3
// BCHK  | banker rule using player third card
// D3    | load dealer card 3
// DONE  | hand resolved, lights valid, held until reset
module deal_sequencer
`ifdef DEAL_PACE_EN
  #(parameter int unsigned PACE_CYCLES = 4)
`endif
(
  input  logic             slow_clock,
  input  logic             reset,
  deal_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_BCHK, S_D3, S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_p;
  logic [3:0] w_d;
  logic [3:0] w_v;
  logic       w_tc;
  logic       w_bank_draw;

  // Out-of-range scores saturate to 9; face cards and tens count as 0.
  assign w_p = (bus.pscore_out > 4'd9) ? 4'd9 : bus.pscore_out;
  assign w_d = (bus.dscore_out > 4'd9) ? 4'd9 : bus.dscore_out;
  assign w_v = (bus.pcard3_out >= 4'd10) ? 4'd0 : bus.pcard3_out;

`ifdef DEAL_PACE_EN
  localparam logic [3:0] LP_RELOAD = 4'(PACE_CYCLES - 1);
  logic [3:0] r_cnt;

  // Reloading on every state change covers entry to each deal state;
  // EVAL/BCHK/DONE simply ignore the count.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (w_next != r_state) begin
      r_cnt <= LP_RELOAD;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign w_tc = (r_cnt == 4'd0);
`else
  assign w_tc = 1'b1;
`endif

  always_comb begin
    w_bank_draw = 1'b0;
    case (w_d)
      4'd0, 4'd1, 4'd2: w_bank_draw = 1'b1;
      4'd3:             w_bank_draw = (w_v != 4'd8);
      4'd4:             w_bank_draw = (w_v >= 4'd2) && (w_v <= 4'd7);
      4'd5:             w_bank_draw = (w_v >= 4'd4) && (w_v <= 4'd7);
      4'd6:             w_bank_draw = (w_v >= 4'd6) && (w_v <= 4'd7);
      default:          w_bank_draw = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_P1;
      S_P1:   if (w_tc) w_next = S_D1;
      S_D1:   if (w_tc) w_next = S_P2;
      S_P2:   if (w_tc) w_next = S_D2;
      S_D2:   if (w_tc) w_next = S_EVAL;
      S_EVAL: begin
        if ((w_p >= 4'd8) || (w_d >= 4'd8)) w_next = S_DONE;
        else if (w_p <= 4'd5)               w_next = S_P3;
        else if (w_d <= 4'd5)               w_next = S_D3;
        else                                w_next = S_DONE;
      end
      S_P3:   if (w_tc) w_next = S_BCHK;
      S_BCHK: w_next = w_bank_draw ? S_D3 : S_DONE;
      S_D3:   if (w_tc) w_next = S_DONE;
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.load_pcard1      = (r_state == S_P1) && w_tc;
    bus.load_dcard1      = (r_state == S_D1) && w_tc;
    bus.load_pcard2      = (r_state == S_P2) && w_tc;
    bus.load_dcard2      = (r_state == S_D2) && w_tc;
    bus.load_pcard3      = (r_state == S_P3) && w_tc;
    bus.load_dcard3      = (r_state == S_D3) && w_tc;
    bus.hand_done        = (r_state == S_DONE);
    bus.player_win_light = (r_state == S_DONE) && (w_p >= w_d);
    bus.dealer_win_light = (r_state == S_DONE) && (w_d >= w_p);
  end

endmodule
